// File: rtl/clk_step_gen_pkg.sv
// picomips_clk_pkg: shared types and defaults for the picoMIPS clock-step
// generator.
//   step_state_t     : encoding of the step FSM, also exposed on the state port
//   DEBOUNCE_DEFAULT : default number of stable fastclk cycles that accept a
//                      new push-button level
package picomips_clk_pkg;

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HOLD = 2'd3
  } step_state_t;

  localparam int DEBOUNCE_DEFAULT = 1000;

endpackage

// File: rtl/clk_step_gen_btn_debounce.sv
// btn_debounce: level debouncer for an already-synchronised push button.
// dout takes the value of din only after din has differed from dout on
// DEBOUNCE_CYCLES consecutive fastclk edges. Any return to the current dout
// level restarts the count.
//   fastclk : system clock
//   reset   : asynchronous, active-high
//   din     : synchronised raw button level
//   dout    : debounced level
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic fastclk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge fastclk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      // din has now differed on DEBOUNCE_CYCLES edges in a row
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clk_step_gen.sv
// clk_step_gen: turns the divided picoMIPS slow clock into single-cycle CPU
// enable pulses on fastclk, either free-running or single-stepped from a push
// button, counts issued ticks and honours a sticky halt from the core.
//   fastclk   : system clock, all logic on its rising edge
//   reset     : asynchronous, active-high
//   slowclk   : divided clock, sampled as asynchronous data
//   run_mode  : 1 = free-run, 0 = single-step (asynchronous switch)
//   step_btn  : raw bouncy push button, active-high (asynchronous)
//   halt      : sticky stop request from the core, synchronous to fastclk
//   tick      : CPU enable, one fastclk cycle per step
//   btn_db    : debounced step_btn level
//   cycle_cnt : ticks issued since reset, wraps silently
//   state     : FSM state
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_HALT | stopped by the core; only reset leaves this state
// S_RUN  | free-run, one tick per slowclk rising edge
// S_STEP | single-step, waiting for a button press
// S_HOLD | single-step, button still down; waiting for release
module clk_step_gen
  import picomips_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic             fastclk,
  input  logic             reset,
  input  logic             slowclk,
  input  logic             run_mode,
  input  logic             step_btn,
  input  logic             halt,
  output logic             tick,
  output logic             btn_db,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       state
);

  step_state_t state_q;

  logic slow_m, slow_s, slow_prev;
  logic run_m, run_s;
  logic btn_m, btn_s;
  logic btn_db_prev;
  logic rise, press, release_ev;

  // Two-flop synchronisers for the three asynchronous inputs, plus the
  // history registers for the slowclk and debounced-button edge detectors.
  always_ff @(posedge fastclk or posedge reset) begin
    if (reset) begin
      slow_m      <= 1'b0;
      slow_s      <= 1'b0;
      slow_prev   <= 1'b0;
      run_m       <= 1'b0;
      run_s       <= 1'b0;
      btn_m       <= 1'b0;
      btn_s       <= 1'b0;
      btn_db_prev <= 1'b0;
    end else begin
      slow_m      <= slowclk;
      slow_s      <= slow_m;
      slow_prev   <= slow_s;
      run_m       <= run_mode;
      run_s       <= run_m;
      btn_m       <= step_btn;
      btn_s       <= btn_m;
      btn_db_prev <= btn_db;
    end
  end

  assign rise       = slow_s & ~slow_prev;
  assign press      = btn_db & ~btn_db_prev;
  assign release_ev = ~btn_db & btn_db_prev;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .fastclk(fastclk),
    .reset  (reset),
    .din    (btn_s),
    .dout   (btn_db)
  );

  // tick and cycle_cnt are updated on the same edge so cycle_cnt already
  // includes a tick while that tick is visible.
  always_ff @(posedge fastclk or posedge reset) begin
    if (reset) begin
      state_q   <= S_STEP;
      tick      <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      tick <= 1'b0;
      if (halt) begin
        state_q <= S_HALT;
      end else begin
        case (state_q)
          S_HALT: begin
          end
          S_RUN: begin
            if (rise) begin
              tick      <= 1'b1;
              cycle_cnt <= cycle_cnt + 1'b1;
            end
            // Leaving with the button down goes to HOLD so the press that
            // is already in progress cannot produce a step.
            if (!run_s) state_q <= btn_db ? S_HOLD : S_STEP;
          end
          S_STEP: begin
            if (press) begin
              tick      <= 1'b1;
              cycle_cnt <= cycle_cnt + 1'b1;
              state_q   <= S_HOLD;
            end else if (run_s) begin
              state_q <= S_RUN;
            end
          end
          S_HOLD: begin
            if (run_s)           state_q <= S_RUN;
            else if (release_ev) state_q <= S_STEP;
          end
        endcase
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_clk_step_gen.sv
module tb_clk_step_gen;

  localparam int DEB   = 4;
  localparam int CNT_W = 4;

  logic             fastclk = 1'b0;
  logic             reset = 1'b0;
  logic             slowclk = 1'b0;
  logic             run_mode = 1'b1;
  logic             step_btn = 1'b0;
  logic             halt = 1'b0;
  logic             tick;
  logic             btn_db;
  logic [CNT_W-1:0] cycle_cnt;
  logic [1:0]       state;

  clk_step_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CNT_W)
  ) dut (
    .fastclk  (fastclk),
    .reset    (reset),
    .slowclk  (slowclk),
    .run_mode (run_mode),
    .step_btn (step_btn),
    .halt     (halt),
    .tick     (tick),
    .btn_db   (btn_db),
    .cycle_cnt(cycle_cnt),
    .state    (state)
  );

  always #5 fastclk = ~fastclk;

  int edge_n = 0;
  always @(posedge fastclk) edge_n <= edge_n + 1;

  int errors = 0;
  int checks = 0;
  int expq[$];      // edge numbers at which a tick must be registered
  int exp_cnt = 0;  // ticks issued since reset, per the model
  int btn_rises = 0;
  logic tick_last = 1'b0;
  logic btn_db_last = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a tick.
  always @(negedge fastclk) begin
    if (!reset) begin
      if (tick) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick: tick at edge %0d, none expected", edge_n);
        end else begin
          int e;
          e = expq.pop_front();
          if (e != edge_n) begin
            errors++;
            $display("FAIL tick_time: tick at edge %0d expected edge %0d", edge_n, e);
          end
          exp_cnt = exp_cnt + 1;
          chk("cycle_cnt_at_tick", int'(cycle_cnt), exp_cnt % (1 << CNT_W));
        end
        chk("tick_width", int'(tick_last), 0);
      end else if (expq.size() > 0 && expq[0] < edge_n) begin
        checks++;
        errors++;
        $display("FAIL missing_tick: no tick by edge %0d expected edge %0d", edge_n, expq[0]);
        void'(expq.pop_front());
      end
      if (btn_db && !btn_db_last) btn_rises++;
    end
    tick_last   = tick;
    btn_db_last = btn_db;
  end

  // One slowclk period; a rise sampled at edge N must tick at edge N+2.
  task automatic slow_pulse(input int half, input bit expect_tick);
    @(negedge fastclk);
    slowclk = 1'b1;
    if (expect_tick) expq.push_back(edge_n + 3);
    repeat (half) @(negedge fastclk);
    slowclk = 1'b0;
    repeat (half - 1) @(negedge fastclk);
  endtask

  // Drive the button to a stable level; the debounced edge follows after
  // 2 sync edges + DEB stable edges, the tick one edge later.
  task automatic btn_level(input logic lvl, input bit expect_tick, input int hold);
    @(negedge fastclk);
    step_btn = lvl;
    if (expect_tick) expq.push_back(edge_n + DEB + 3);
    repeat (hold - 1) @(negedge fastclk);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge fastclk);
  endtask

  task automatic do_reset();
    @(negedge fastclk);
    reset = 1'b1;
    expq.delete();
    exp_cnt = 0;
    wait_cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int base_rises;
    int cnt_before;
    bit bpat [4];
    bpat = '{1'b1, 1'b0, 1'b1, 1'b0};

    // Reset values
    #1 reset = 1'b1;
    wait_cyc(2);
    chk("rst_tick", int'(tick), 0);
    chk("rst_btn_db", int'(btn_db), 0);
    chk("rst_cycle_cnt", int'(cycle_cnt), 0);
    chk("rst_state", int'(state), 2);
    reset = 1'b0;
    wait_cyc(2);
    chk("state_still_step", int'(state), 2);
    wait_cyc(1);
    chk("state_run_after_3", int'(state), 1);

    // 1: free-run, 5 slowclk periods of 16 fastclk cycles
    for (int i = 0; i < 5; i++) slow_pulse(8, 1'b1);
    wait_cyc(6);
    chk("t1_queue_empty", expq.size(), 0);
    chk("t1_cycle_cnt", int'(cycle_cnt), 5);

    // 2: single-step with a bouncy press
    run_mode = 1'b0;
    wait_cyc(4);
    chk("t2_state_step", int'(state), 2);
    base_rises = btn_rises;
    for (int i = 0; i < 4; i++) begin
      @(negedge fastclk);
      step_btn = bpat[i];
    end
    btn_level(1'b1, 1'b1, 10);
    wait_cyc(2);
    chk("t2_state_hold", int'(state), 3);
    chk("t2_cycle_cnt", int'(cycle_cnt), 6);
    chk("t2_btn_rises", btn_rises - base_rises, 1);
    btn_level(1'b0, 1'b0, 10);
    chk("t2_state_release", int'(state), 2);
    chk("t2_btn_db_low", int'(btn_db), 0);
    chk("t2_queue_empty", expq.size(), 0);

    // 3: mode switch while the button is held lands in HOLD
    run_mode = 1'b1;
    wait_cyc(4);
    chk("t3_state_run", int'(state), 1);
    for (int i = 0; i < int'($urandom_range(2, 4)); i++)
      slow_pulse(int'($urandom_range(3, 8)), 1'b1);
    btn_level(1'b1, 1'b0, DEB + 6);
    chk("t3_btn_db_high", int'(btn_db), 1);
    chk("t3_state_run_held", int'(state), 1);
    run_mode = 1'b0;
    wait_cyc(4);
    chk("t3_state_hold", int'(state), 3);
    btn_level(1'b0, 1'b0, 10);
    chk("t3_state_step", int'(state), 2);
    btn_level(1'b1, 1'b1, DEB + 6);
    chk("t3_state_hold2", int'(state), 3);
    btn_level(1'b0, 1'b0, 10);
    chk("t3_queue_empty", expq.size(), 0);

    // 4: halt on the very edge a tick would be registered
    run_mode = 1'b1;
    wait_cyc(4);
    chk("t4_state_run", int'(state), 1);
    cnt_before = int'(cycle_cnt);
    @(negedge fastclk);
    slowclk = 1'b1;          // sampled at edge N, tick would be at N+2
    @(negedge fastclk);
    @(negedge fastclk);
    halt = 1'b1;             // sampled at edge N+2
    @(negedge fastclk);
    halt = 1'b0;
    slowclk = 1'b0;
    chk("t4_state_halt", int'(state), 0);
    for (int i = 0; i < 3; i++) slow_pulse(int'($urandom_range(3, 8)), 1'b0);
    run_mode = 1'b0;
    wait_cyc(4);
    btn_level(1'b1, 1'b0, DEB + 6);
    btn_level(1'b0, 1'b0, DEB + 6);
    run_mode = 1'b1;
    wait_cyc(4);
    chk("t4_still_halt", int'(state), 0);
    chk("t4_cnt_frozen", int'(cycle_cnt), cnt_before);
    do_reset();

    // 5: 17 ticks wrap a 4-bit counter to 1
    wait_cyc(3);
    chk("t5_state_run", int'(state), 1);
    for (int i = 0; i < 17; i++) slow_pulse(int'($urandom_range(3, 7)), 1'b1);
    wait_cyc(4);
    chk("t5_queue_empty", expq.size(), 0);
    chk("t5_cycle_cnt_wrap", int'(cycle_cnt), 1);

    // 6: asynchronous reset mid-HOLD with a partly counted debounce
    run_mode = 1'b0;
    wait_cyc(4);
    chk("t6_state_step", int'(state), 2);
    btn_level(1'b1, 1'b1, DEB + 6);
    btn_level(1'b0, 1'b0, DEB + 6);
    btn_level(1'b1, 1'b1, DEB + 6);
    chk("t6_state_hold", int'(state), 3);
    chk("t6_cnt_before", int'(cycle_cnt), 3);
    step_btn = 1'b0;
    wait_cyc(4);             // debounce count is part-way, btn_db still 1
    chk("t6_btn_db_high", int'(btn_db), 1);
    step_btn = 1'b1;
    #2 reset = 1'b1;
    expq.delete();
    exp_cnt = 0;
    #1;
    chk("t6_async_tick", int'(tick), 0);
    chk("t6_async_btn_db", int'(btn_db), 0);
    chk("t6_async_cnt", int'(cycle_cnt), 0);
    chk("t6_async_state", int'(state), 2);
    wait_cyc(2);
    reset = 1'b0;
    expq.push_back(edge_n + DEB + 3);
    wait_cyc(DEB + 6);
    chk("t6_state_hold_after", int'(state), 3);
    chk("t6_cycle_cnt", int'(cycle_cnt), 1);
    chk("t6_queue_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
